// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared dispatch types: FSM states, stall causes, ROB id size.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

  localparam int ROB_DEPTH_DEF = 16;
  localparam int ROB_ID_SIZE   = $clog2(ROB_DEPTH_DEF);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } dispatch_state_t;

  typedef enum logic [1:0] {
    SC_NONE        = 2'b00,
    SC_ROB_FULL    = 2'b01,
    SC_RS_LSQ_FULL = 2'b10,
    SC_FLUSH       = 2'b11
  } stall_cause_t;

endpackage

`default_nettype wire

// File: rtl/dispatch_ctrl_credit_counter.sv
// ============================================================================
// Module      : credit_counter
// Description : Free-slot counter, DEPTH at reset/clear, saturating at DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module credit_counter #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          take,
  input  logic          give,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam logic [CW:0] c_DEPTH = (CW+1)'(DEPTH);

  logic [CW-1:0] r_count;
  logic [CW:0]   w_sum;

  // take is only asserted with a non-zero count, so the sum never underflows
  assign w_sum = {1'b0, r_count} + {{CW{1'b0}}, give} - {{CW{1'b0}}, take};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= c_DEPTH[CW-1:0];
    end else if (w_sum > c_DEPTH) begin
      r_count <= c_DEPTH[CW-1:0];
    end else begin
      r_count <= w_sum[CW-1:0];
    end
  end

  assign count = r_count;
  assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/dispatch_ctrl.sv
// ============================================================================
// Module      : dispatch_ctrl
// Description : Credit-gated dispatch from IQ head into decode, with flush FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dispatch_ctrl
  import rv32i_types::*;
#(
  parameter int ROB_DEPTH    = 16,
  parameter int RS_DEPTH     = 8,
  parameter int LSQ_DEPTH    = 8,
  parameter int ROB_ID_W     = ROB_ID_SIZE,
  parameter int AGE_W        = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iq_valid,
  input  logic                iq_is_mem,
  input  logic                branch_mispredict,
  input  logic                rob_commit,
  input  logic                rs_issue,
  input  logic                lsq_release,
  output logic                iq_pop,
  output logic                valid_inst,
  output logic [ROB_ID_W-1:0] rob_id_dest,
  output logic [AGE_W-1:0]    ls_age,
  output logic [1:0]          stall_cause,
  output logic [31:0]         stall_cnt
);

  localparam int FCW = $clog2(FLUSH_CYCLES) + 1;

  dispatch_state_t r_state, w_next_state;
  logic [FCW-1:0]  r_flush_cnt, w_next_flush_cnt;
  logic [ROB_ID_W-1:0] r_tail;
  logic [AGE_W-1:0]    r_age;
  logic [31:0]         r_stall_cnt;
  stall_cause_t        w_cause;

  logic w_run, w_accept, w_fire, w_need_free;
  logic w_rob_empty, w_rs_empty, w_lsq_empty;
  logic [$clog2(ROB_DEPTH+1)-1:0] w_rob_free;
  logic [$clog2(RS_DEPTH+1)-1:0]  w_rs_free;
  logic [$clog2(LSQ_DEPTH+1)-1:0] w_lsq_free;

  assign w_run       = (r_state == ST_RUN);
  // releases count only in RUN cycles that are not being flushed
  assign w_accept    = w_run && !branch_mispredict;
  assign w_need_free = iq_is_mem ? !w_lsq_empty : !w_rs_empty;
  assign w_fire      = !rst && w_accept && iq_valid && !w_rob_empty && w_need_free;

  credit_counter #(.DEPTH(ROB_DEPTH)) u_rob_cred (
    .clk(clk), .rst(rst), .take(w_fire), .give(rob_commit && w_accept),
    .clear(branch_mispredict), .count(w_rob_free), .empty(w_rob_empty)
  );

  credit_counter #(.DEPTH(RS_DEPTH)) u_rs_cred (
    .clk(clk), .rst(rst), .take(w_fire && !iq_is_mem), .give(rs_issue && w_accept),
    .clear(branch_mispredict), .count(w_rs_free), .empty(w_rs_empty)
  );

  credit_counter #(.DEPTH(LSQ_DEPTH)) u_lsq_cred (
    .clk(clk), .rst(rst), .take(w_fire && iq_is_mem), .give(lsq_release && w_accept),
    .clear(branch_mispredict), .count(w_lsq_free), .empty(w_lsq_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_flush_cnt <= w_next_flush_cnt;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_next_flush_cnt = r_flush_cnt;
    if (branch_mispredict) begin
      w_next_state     = ST_FLUSH;
      w_next_flush_cnt = FCW'(FLUSH_CYCLES - 1);
    end else if (r_state == ST_FLUSH) begin
      if (r_flush_cnt == '0) begin
        w_next_state = ST_RUN;
      end else begin
        w_next_flush_cnt = r_flush_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    w_cause = SC_NONE;
    if (rst || !iq_valid) begin
      w_cause = SC_NONE;
    end else if (!w_accept) begin
      w_cause = SC_FLUSH;
    end else if (w_rob_empty) begin
      w_cause = SC_ROB_FULL;
    end else if (!w_need_free) begin
      w_cause = SC_RS_LSQ_FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || branch_mispredict) begin
      r_tail <= '0;
      r_age  <= '0;
    end else if (w_fire) begin
      r_tail <= r_tail + 1'b1;
      if (iq_is_mem) begin
        r_age <= r_age + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (iq_valid && !w_fire && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign iq_pop      = w_fire;
  assign valid_inst  = w_fire;
  assign rob_id_dest = rst ? '0 : r_tail;
  assign ls_age      = rst ? '0 : r_age;
  assign stall_cause = w_cause;
  assign stall_cnt   = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dispatch_ctrl.sv
// ============================================================================
// Module      : tb_dispatch_ctrl
// Description : Scoreboard bench for dispatch_ctrl against a slot-count model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dispatch_ctrl;

  localparam int ROB_D = 16;
  localparam int RS_D  = 8;
  localparam int LSQ_D = 8;
  localparam int FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iq_valid = 1'b0, iq_is_mem = 1'b0, branch_mispredict = 1'b0;
  logic        rob_commit = 1'b0, rs_issue = 1'b0, lsq_release = 1'b0;
  logic        iq_pop, valid_inst;
  logic [3:0]  rob_id_dest;
  logic [15:0] ls_age;
  logic [1:0]  stall_cause;
  logic [31:0] stall_cnt;

  dispatch_ctrl dut (
    .clk(clk), .rst(rst), .iq_valid(iq_valid), .iq_is_mem(iq_is_mem),
    .branch_mispredict(branch_mispredict), .rob_commit(rob_commit),
    .rs_issue(rs_issue), .lsq_release(lsq_release), .iq_pop(iq_pop),
    .valid_inst(valid_inst), .rob_id_dest(rob_id_dest), .ls_age(ls_age),
    .stall_cause(stall_cause), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit rst; bit fire; int cause; longint scnt; } cyc_t;
  typedef struct { int rob_id; int age; } txn_t;
  cyc_t cq[$];
  txn_t tq[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: free slot counts, next ROB id, next age, flush cycles left
  int m_rob, m_rs, m_lsq, m_tail, m_age, m_flush_left;
  longint m_stall;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_rob = ROB_D; m_rs = RS_D; m_lsq = LSQ_D;
    m_tail = 0; m_age = 0; m_flush_left = 0; m_stall = 0;
  endtask

  task automatic step(input bit r, input bit v, input bit m, input bit mis,
                      input bit cm, input bit is, input bit rel);
    cyc_t e;
    bit   fire;
    int   cause;
    @(posedge clk);
    #1;
    rst = r; iq_valid = v; iq_is_mem = m; branch_mispredict = mis;
    rob_commit = cm; rs_issue = is; lsq_release = rel;

    fire = !r && (m_flush_left == 0) && v && !mis && (m_rob > 0) &&
           (m ? (m_lsq > 0) : (m_rs > 0));
    if (r || !v)                          cause = 0;
    else if (mis || m_flush_left > 0)     cause = 3;
    else if (m_rob == 0)                  cause = 1;
    else if ((m ? m_lsq : m_rs) == 0)     cause = 2;
    else                                  cause = 0;

    e.rst = r; e.fire = fire; e.cause = cause; e.scnt = m_stall;
    cq.push_back(e);
    if (fire) tq.push_back('{rob_id: m_tail, age: m_age});

    if (r) begin
      model_reset();
    end else begin
      if (v && !fire) m_stall++;
      if (mis) begin
        m_rob = ROB_D; m_rs = RS_D; m_lsq = LSQ_D;
        m_tail = 0; m_age = 0; m_flush_left = FLUSH;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else begin
        m_rob = min2(ROB_D, m_rob - int'(fire) + int'(cm));
        m_rs  = min2(RS_D,  m_rs  - int'(fire && !m) + int'(is));
        m_lsq = min2(LSQ_D, m_lsq - int'(fire && m)  + int'(rel));
        if (fire) m_tail = (m_tail + 1) % ROB_D;
        if (fire && m) m_age = (m_age + 1) % 65536;
      end
    end
  endtask

  always @(negedge clk) begin
    if (cq.size() > 0) begin
      cyc_t e;
      e = cq.pop_front();
      chk("valid_inst", longint'(valid_inst), longint'(e.fire));
      chk("iq_pop", longint'(iq_pop), longint'(e.fire));
      chk("stall_cause", longint'(stall_cause), longint'(e.cause));
      chk("stall_cnt", longint'(stall_cnt), e.scnt);
      if (e.rst) begin
        chk("rob_id_in_rst", longint'(rob_id_dest), 0);
        chk("ls_age_in_rst", longint'(ls_age), 0);
      end
      if (valid_inst) begin
        if (tq.size() == 0) begin
          chk("unexpected_fire", 1, 0);
        end else begin
          txn_t t;
          t = tq.pop_front();
          chk("rob_id_dest", longint'(rob_id_dest), longint'(t.rob_id));
          chk("ls_age", longint'(ls_age), longint'(t.age));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(posedge clk);
    // Non-mem stream without releases: RS limits to 8 fires
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0, 0, 0, 0);

    // Mem stream, LSQ released every 2nd cycle
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) step(0, 1, 1, 0, 1, 0, i[0]);

    // Fill the ROB, one commit, 17th fire wraps to id 0
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0);

    // Fire and rs_issue together at one free RS slot
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 1, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);

    // Mispredict with a valid head, flush, then restart from id 0 / age 0
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1, 1);
    step(0, 1, 1, 0, 1, 1, 1);
    step(0, 1, 1, 0, 1, 1, 1);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);

    // Reset mid-stream with RS credits at 3
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 1, 1);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 8,
           1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 2) == 0);
    end

    step(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    chk("pending_cycles", longint'(cq.size()), 0);
    chk("pending_fires", longint'(tq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
